// File: rtl/contador_regressivo.sv
// Loadable down-counter/timer with one-shot and periodic modes.
// Flags the terminal count with a one-cycle pulse and a sticky expiry bit.
module contador_regressivo #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned RECARGA_INICIAL = 0
) (
  input  logic             clock,
  input  logic             zera,
  input  logic             carrega,
  input  logic [WIDTH-1:0] valor,
  input  logic             inicia,
  input  logic             pausa,
  input  logic             conta,
  input  logic             periodico,
  input  logic             limpa,
  output logic [WIDTH-1:0] contagem,
  output logic             fim,
  output logic             ativo,
  output logic             expirou
);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    ESGOTADO = 2'd3
  } estado_t;

  localparam logic [WIDTH-1:0] RECARGA_RST = WIDTH'(RECARGA_INICIAL);
  localparam logic [WIDTH-1:0] UM          = WIDTH'(1);

  estado_t          state, state_n;
  logic [WIDTH-1:0] recarga, recarga_n;
  logic [WIDTH-1:0] contagem_n;
  logic             fim_n;
  logic             expirou_n;
  logic             terminal;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (zera) begin
      state    <= PARADO;
      recarga  <= RECARGA_RST;
      contagem <= RECARGA_RST;
      fim      <= 1'b0;
      ativo    <= 1'b0;
      expirou  <= 1'b0;
    end else begin
      state    <= state_n;
      recarga  <= recarga_n;
      contagem <= contagem_n;
      fim      <= fim_n;
      ativo    <= (state_n == CONTANDO);
      expirou  <= expirou_n;
    end
  end

  // Next-state, count and flag logic; load beats start beats counting
  always_comb begin
    state_n    = state;
    recarga_n  = recarga;
    contagem_n = contagem;
    fim_n      = 1'b0;
    expirou_n  = expirou;
    terminal   = 1'b0;

    if (carrega) begin
      recarga_n  = valor;
      contagem_n = valor;
      state_n    = PARADO;
    end else if (inicia) begin
      if (state == CONTANDO) begin
        contagem_n = recarga;
      end else if (recarga != '0) begin
        state_n = CONTANDO;
        if (contagem == '0) begin
          contagem_n = recarga;
        end
      end
    end else begin
      unique case (state)
        CONTANDO: begin
          if (pausa) begin
            state_n = PAUSADO;
          end else if (conta && contagem != '0) begin
            if (contagem == UM) begin
              terminal = 1'b1;
              fim_n    = 1'b1;
              if (periodico) begin
                contagem_n = recarga;
              end else begin
                contagem_n = '0;
                state_n    = ESGOTADO;
              end
            end else begin
              contagem_n = contagem - UM;
            end
          end
        end
        PAUSADO: begin
          if (!pausa) begin
            state_n = CONTANDO;
          end
        end
        default: ;
      endcase
    end

    // Sticky expiry: a one-shot terminal tick sets it and outranks limpa
    if (carrega) begin
      expirou_n = 1'b0;
    end else if (terminal && !periodico) begin
      expirou_n = 1'b1;
    end else if (limpa) begin
      expirou_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: directed scenarios plus
// randomized traffic checked against a behavioural timer model.
module tb_contador_regressivo;

  logic       clock = 1'b0;
  logic       zera, carrega, inicia, pausa, conta, periodico, limpa;
  logic [7:0] valor;
  logic [3:0] valor4;
  logic [7:0] contagem;
  logic [3:0] contagem4;
  logic       fim, ativo, expirou;
  logic       fim4, ativo4, expirou4;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the 8-bit timer
  logic [7:0] m_count, m_reload;
  bit         m_running, m_paused, m_fim, m_exp;

  always #5 clock = ~clock;

  contador_regressivo #(.WIDTH(8), .RECARGA_INICIAL(0)) dut (
    .clock(clock), .zera(zera), .carrega(carrega), .valor(valor),
    .inicia(inicia), .pausa(pausa), .conta(conta), .periodico(periodico),
    .limpa(limpa), .contagem(contagem), .fim(fim), .ativo(ativo),
    .expirou(expirou)
  );

  contador_regressivo #(.WIDTH(4), .RECARGA_INICIAL(9)) dut4 (
    .clock(clock), .zera(zera), .carrega(carrega), .valor(valor4),
    .inicia(inicia), .pausa(pausa), .conta(conta), .periodico(periodico),
    .limpa(limpa), .contagem(contagem4), .fim(fim4), .ativo(ativo4),
    .expirou(expirou4)
  );

  task automatic model_edge();
    bit expire_now;
    expire_now = 0;
    if (zera) begin
      m_count = 0; m_reload = 0; m_running = 0; m_paused = 0; m_fim = 0; m_exp = 0;
    end else if (carrega) begin
      m_reload = valor; m_count = valor; m_running = 0; m_paused = 0; m_fim = 0; m_exp = 0;
    end else begin
      m_fim = 0;
      if (inicia) begin
        if (m_running) m_count = m_reload;
        else if (m_reload != 0) begin
          if (m_count == 0) m_count = m_reload;
          m_running = 1; m_paused = 0;
        end
      end else if (m_running) begin
        if (pausa) begin
          m_running = 0; m_paused = 1;
        end else if (conta && m_count > 0) begin
          m_count = m_count - 8'd1;
          if (m_count == 0) begin
            m_fim = 1;
            if (periodico) m_count = m_reload;
            else begin m_running = 0; expire_now = 1; end
          end
        end
      end else if (m_paused && !pausa) begin
        m_paused = 0; m_running = 1;
      end
      if (expire_now) m_exp = 1;
      else if (limpa) m_exp = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    zera = 0; carrega = 0; inicia = 0; pausa = 0; conta = 0; periodico = 0; limpa = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    zera = 1;
    step();
    zera = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (contagem !== 8'd0) begin n_err++; $display("FAIL reset_contagem got %0d want 0", contagem); end
    n_cmp++; if ({fim, ativo, expirou} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {fim, ativo, expirou}); end
    n_cmp++; if (contagem4 !== 4'd9) begin n_err++; $display("FAIL reset_recarga_inicial got %0d want 9", contagem4); end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    carrega = 1; valor = 8'd10; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    conta = 1; repeat (4) step();
    n_cmp++; if (contagem !== 8'd6) begin n_err++; $display("FAIL midcount_before_reset got %0d want 6", contagem); end
    zera = 1; step(); zera = 0; conta = 0;
    n_cmp++; if ({contagem, fim, ativo, expirou} !== {8'd0, 3'b000}) begin
      n_err++; $display("FAIL midcount_reset got cnt=%0d f/a/e=%b want 0/000", contagem, {fim, ativo, expirou});
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    carrega = 1; valor = 8'd5; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    n_cmp++; if (contagem !== 8'd5 || ativo !== 1'b1) begin n_err++; $display("FAIL oneshot_start got cnt=%0d ativo=%b want 5/1", contagem, ativo); end
    conta = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++; if (contagem !== 8'(5 - i) || fim !== (i == 5)) begin
        n_err++; $display("FAIL oneshot_tick%0d got cnt=%0d fim=%b want %0d/%b", i, contagem, fim, 5 - i, i == 5);
      end
    end
    n_cmp++; if (expirou !== 1'b1 || ativo !== 1'b0) begin n_err++; $display("FAIL oneshot_done got exp=%b ativo=%b want 1/0", expirou, ativo); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (contagem !== 8'd0 || fim !== 1'b0 || expirou !== 1'b1) begin
        n_err++; $display("FAIL oneshot_hold got cnt=%0d fim=%b exp=%b want 0/0/1", contagem, fim, expirou);
      end
    end
    conta = 0;
  endtask

  task automatic test_periodic();
    do_reset();
    carrega = 1; valor = 8'd3; step(); carrega = 0;
    periodico = 1; inicia = 1; step(); inicia = 0;
    conta = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++; if (contagem !== 8'((k % 3 == 0) ? 3 : 3 - k % 3) || fim !== (k % 3 == 0) || ativo !== 1'b1) begin
        n_err++; $display("FAIL periodic_tick%0d got cnt=%0d fim=%b ativo=%b", k, contagem, fim, ativo);
      end
    end
    n_cmp++; if (expirou !== 1'b0) begin n_err++; $display("FAIL periodic_no_expire got %b want 0", expirou); end
    conta = 0; periodico = 0;
  endtask

  task automatic test_pause();
    do_reset();
    carrega = 1; valor = 8'd8; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    conta = 1; repeat (3) step();
    n_cmp++; if (contagem !== 8'd5) begin n_err++; $display("FAIL pause_pre got %0d want 5", contagem); end
    pausa = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (contagem !== 8'd5 || ativo !== 1'b0) begin n_err++; $display("FAIL pause_hold got cnt=%0d ativo=%b want 5/0", contagem, ativo); end
    end
    pausa = 0; step();
    n_cmp++; if (contagem !== 8'd5 || ativo !== 1'b1) begin n_err++; $display("FAIL pause_release got cnt=%0d ativo=%b want 5/1", contagem, ativo); end
    step();
    n_cmp++; if (contagem !== 8'd4) begin n_err++; $display("FAIL pause_resume got %0d want 4", contagem); end
    conta = 0;
  endtask

  task automatic test_corners();
    do_reset();
    carrega = 1; valor = 8'd0; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    conta = 1; repeat (2) step(); conta = 0;
    n_cmp++; if ({ativo, fim, contagem} !== {2'b00, 8'd0}) begin n_err++; $display("FAIL zero_reload got ativo=%b fim=%b cnt=%0d want 0/0/0", ativo, fim, contagem); end
    carrega = 1; inicia = 1; valor = 8'd7; step(); carrega = 0; inicia = 0;
    n_cmp++; if (ativo !== 1'b0 || contagem !== 8'd7) begin n_err++; $display("FAIL load_beats_start got ativo=%b cnt=%0d want 0/7", ativo, contagem); end
    carrega = 1; valor = 8'd2; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    conta = 1; step();
    limpa = 1; step(); conta = 0;
    n_cmp++; if (fim !== 1'b1 || expirou !== 1'b1) begin n_err++; $display("FAIL limpa_vs_set got fim=%b exp=%b want 1/1", fim, expirou); end
    step(); limpa = 0;
    n_cmp++; if (expirou !== 1'b0) begin n_err++; $display("FAIL limpa_clear got %b want 0", expirou); end
  endtask

  task automatic test_max_width();
    do_reset();
    carrega = 1; valor4 = 4'd15; valor = 8'd15; step(); carrega = 0;
    inicia = 1; step(); inicia = 0;
    conta = 1;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_cmp++; if (contagem4 !== ((k >= 15) ? 4'd0 : 4'(15 - k)) || fim4 !== (k == 15)) begin
        n_err++; $display("FAIL max_width_tick%0d got cnt=%0d fim=%b", k, contagem4, fim4);
      end
    end
    n_cmp++; if (expirou4 !== 1'b1 || ativo4 !== 1'b0) begin n_err++; $display("FAIL max_width_done got exp=%b ativo=%b want 1/0", expirou4, ativo4); end
    conta = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      zera    = ($urandom_range(0, 299) == 0);
      carrega = ($urandom_range(0, 24) == 0);
      valor   = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      valor4  = valor[3:0];
      inicia  = ($urandom_range(0, 19) == 0);
      pausa   = ($urandom_range(0, 9) == 0);
      conta   = ($urandom_range(0, 2) != 0);
      limpa   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) periodico = ~periodico;
      step();
      n_cmp++; if ({contagem, fim, ativo, expirou} !== {m_count, m_fim, m_running, m_exp}) begin
        n_err++; $display("FAIL random_cycle%0d got cnt=%0d f/a/e=%b want cnt=%0d f/a/e=%b",
                          c, contagem, {fim, ativo, expirou}, m_count, {m_fim, m_running, m_exp});
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    valor = 8'd0; valor4 = 4'd0;
    @(negedge clock);
    test_reset();
    test_reset_mid_count();
    test_one_shot();
    test_periodic();
    test_pause();
    test_corners();
    test_max_width();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
